// File: rtl/apx_pkg.sv
// Shared types and default sizing for the truncated-add frame accumulator.
package apx_pkg;

    localparam int APX_BWOP  = 32;
    localparam int APX_NAB   = 1;
    localparam int APX_LEN_W = 8;
    // Width of the part of an operand that actually takes part in the add.
    localparam int APX_TW    = APX_BWOP - APX_NAB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } apx_state_e;

endpackage

// File: rtl/apx_acc_if.sv
// Beat-in / sum-out handshake bundle of apx_acc; master drives beats, slave is the accumulator.
interface apx_acc_if #(
    parameter int BWOP  = 32,
    parameter int LEN_W = 8
);
    logic [LEN_W-1:0] i_len;
    logic             i_valid;
    logic             o_ready;
    logic [BWOP-1:0]  i_din;
    logic             o_valid;
    logic             i_ready;
    logic [BWOP-1:0]  o_dout;
    logic             o_ovf;

    modport master (
        output i_len, i_valid, i_din, i_ready,
        input  o_ready, o_valid, o_dout, o_ovf
    );

    modport slave (
        input  i_len, i_valid, i_din, i_ready,
        output o_ready, o_valid, o_dout, o_ovf
    );
endinterface

// File: rtl/apx_acc_dp.sv
// Truncated add of two operands with carry-out; APX_ACC_SAT_EN selects saturation instead of wrap.
module apx_acc_dp
    import apx_pkg::*;
#(
    parameter int BWOP = APX_BWOP,
    parameter int NAB  = APX_NAB
) (
    input  logic [BWOP-1:0] i_a,
    input  logic [BWOP-1:0] i_b,
    output logic [BWOP-1:0] o_sum,
    output logic            o_carry
);

    localparam int TW = BWOP - NAB;

    logic [BWOP:0]   s_full;
    logic [BWOP-1:0] wrap_sum;

    // Shifting before the add drops the NAB LSBs; bit TW of the sum is the carry.
    always_comb begin
        s_full   = ({1'b0, i_a} >> NAB) + ({1'b0, i_b} >> NAB);
        o_carry  = s_full[TW];
        wrap_sum = BWOP'(s_full << NAB);
    end

`ifdef APX_ACC_SAT_EN
    localparam logic [BWOP-1:0] SAT_VAL = {BWOP{1'b1}} << NAB;
    assign o_sum = o_carry ? SAT_VAL : wrap_sum;
`else
    assign o_sum = wrap_sum;
`endif

endmodule

// File: rtl/apx_acc.sv
// Frame accumulator: sums i_len truncated beats, then holds the sum until accepted.
// Optional macro APX_ACC_SAT_EN makes the sum saturate instead of wrapping.
module apx_acc
    import apx_pkg::*;
#(
    parameter int BWOP  = APX_BWOP,
    parameter int NAB   = APX_NAB,
    parameter int LEN_W = APX_LEN_W
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    apx_acc_if.slave  bus
);

    apx_state_e       state_q, state_d;
    logic [BWOP-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             ready_int;
    logic             accept;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] cnt_inc;
    logic [BWOP-1:0]  dp_a;
    logic [BWOP-1:0]  dp_sum;
    logic             dp_carry;

    assign accept  = bus.i_valid & ready_int;
    assign len_eff = (bus.i_len == '0) ? LEN_W'(1) : bus.i_len;
    assign cnt_inc = cnt_q + LEN_W'(1);

    // The first beat of a frame adds onto zero, which is just its truncation.
    assign dp_a = (state_q == ST_ACC) ? acc_q : '0;

    apx_acc_dp #(
        .BWOP (BWOP),
        .NAB  (NAB)
    ) u_dp (
        .i_a     (dp_a),
        .i_b     (bus.i_din),
        .o_sum   (dp_sum),
        .o_carry (dp_carry)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (len_eff == LEN_W'(1)) ? ST_HOLD : ST_ACC;
            ST_ACC:  if (accept && (cnt_inc == len_q)) state_d = ST_HOLD;
            ST_HOLD: if (bus.i_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_int   = (state_q != ST_HOLD);
        bus.o_ready = ready_int;
        bus.o_valid = (state_q == ST_HOLD);
        bus.o_dout  = (state_q == ST_HOLD) ? acc_q : '0;
        bus.o_ovf   = (state_q == ST_HOLD) ? ovf_q : 1'b0;
    end

    // Frame datapath: length is latched on the first beat only.
    always_comb begin
        acc_d = acc_q;
        len_d = len_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (accept) begin
            acc_d = dp_sum;
            if (state_q == ST_IDLE) begin
                len_d = len_eff;
                cnt_d = LEN_W'(1);
                ovf_d = 1'b0;
            end else begin
                cnt_d = cnt_inc;
                ovf_d = ovf_q | dp_carry;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_apx_acc.sv
// Self-checking bench for apx_acc: directed vector table, hand sequences, random frames vs model.
module tb_apx_acc;

    localparam int BWOP  = 32;
    localparam int NAB   = 1;
    localparam int LEN_W = 8;
    localparam int TW    = BWOP - NAB;
`ifdef APX_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    apx_acc_if #(.BWOP(BWOP), .LEN_W(LEN_W)) bus ();

    apx_acc #(
        .BWOP  (BWOP),
        .NAB   (NAB),
        .LEN_W (LEN_W)
    ) u_dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Present one beat and keep it up until the DUT takes it.
    task automatic push_beat(input logic [31:0] d, input logic [7:0] l);
        int w = 0;
        bus.i_valid = 1'b1;
        bus.i_din   = d;
        bus.i_len   = l;
        while (!bus.o_ready && w < 20) begin
            @(negedge i_clk);
            w++;
        end
        if (!bus.o_ready) chk("accept_timeout", 32'(bus.o_ready), 32'd1);
        @(negedge i_clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic take_sum(input int delay, output logic [31:0] d, output logic o);
        int w = 0;
        while (!bus.o_valid && w < 20) begin
            @(negedge i_clk);
            w++;
        end
        if (!bus.o_valid) chk("sum_timeout", 32'(bus.o_valid), 32'd1);
        repeat (delay) @(negedge i_clk);
        d = bus.o_dout;
        o = bus.o_ovf;
        bus.i_ready = 1'b1;
        @(negedge i_clk);
        bus.i_ready = 1'b0;
    endtask

    // Reference: total the truncated operands as plain integers; any carry means the total passed 2^TW.
    function automatic void model(input logic [31:0] b[$], output logic [31:0] d, output logic o);
        longint unsigned tot = 0;
        longint unsigned lim = 64'd1 << TW;
        foreach (b[i]) tot += longint'(b[i] >> NAB);
        o = (tot >= lim);
        if (o && SAT) d = 32'hFFFF_FFFF << NAB;
        else          d = 32'((tot % lim) << NAB);
    endfunction

    typedef struct {
        logic [7:0]       len;
        int               n;
        logic [3:0][31:0] beats;
        logic [3:0][3:0]  gap;
        logic [31:0]      exp_dout;
        logic             exp_ovf;
    } vec_t;

    vec_t vt[7];

    initial begin : wdog
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] d;
        logic        o;
        logic [31:0] q[$];
        logic [31:0] ed;
        logic        eo;
        int          len, n;

        vt[0] = '{8'd3, 3, {32'd0, 32'd7, 32'd6, 32'd5}, {4'd0, 4'd0, 4'd0, 4'd0}, 32'd16, 1'b0};
        vt[1] = '{8'd2, 2, {32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF}, '0,
                  SAT ? 32'hFFFF_FFFE : 32'h0, 1'b1};
        vt[2] = '{8'd0, 1, {32'd0, 32'd0, 32'd0, 32'd9}, '0, 32'd8, 1'b0};
        vt[3] = '{8'd3, 3, {32'd0, 32'd6, 32'd4, 32'd2}, {4'd0, 4'd2, 4'd1, 4'd0}, 32'd12, 1'b0};
        vt[4] = '{8'd2, 2, {32'd0, 32'd0, 32'h8000_0001, 32'h8000_0000}, '0,
                  SAT ? 32'hFFFF_FFFE : 32'h0, 1'b1};
        vt[5] = '{8'd2, 2, {32'd0, 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF}, '0, 32'hFFFF_FFFC, 1'b0};
        vt[6] = '{8'd4, 4, {32'd1, 32'd1, 32'd1, 32'd1}, '0, 32'd0, 1'b0};

        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_din   = '0;
        bus.i_len   = '0;

        repeat (2) @(negedge i_clk);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_dout",  bus.o_dout,       32'd0);
        chk("rst_ovf",   32'(bus.o_ovf),   32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 7; i++) begin
            for (int b = 0; b < vt[i].n; b++) begin
                repeat (int'(vt[i].gap[b])) @(negedge i_clk);
                push_beat(vt[i].beats[b], (b == 0) ? vt[i].len : 8'hA5);
            end
            chk($sformatf("vec%0d_latency", i), 32'(bus.o_valid), 32'd1);
            take_sum(0, d, o);
            chk($sformatf("vec%0d_dout", i), d, vt[i].exp_dout);
            chk($sformatf("vec%0d_ovf", i), 32'(o), 32'(vt[i].exp_ovf));
            $display("vec %0d: len=%0d dout=0x%08h ovf=%0b", i, vt[i].len, d, o);
        end

        // Backpressure: outputs frozen, input pulses ignored while holding.
        push_beat(32'h11, 8'd1);
        for (int k = 0; k < 5; k++) begin
            bus.i_valid = k[0];
            bus.i_din   = $urandom;
            chk("bp_valid", 32'(bus.o_valid), 32'd1);
            chk("bp_dout",  bus.o_dout,       32'h10);
            chk("bp_ovf",   32'(bus.o_ovf),   32'd0);
            chk("bp_ready", 32'(bus.o_ready), 32'd0);
            @(negedge i_clk);
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge i_clk);
        bus.i_ready = 1'b0;
        chk("bp_rel_valid", 32'(bus.o_valid), 32'd0);
        chk("bp_rel_ready", 32'(bus.o_ready), 32'd1);
        push_beat(32'd3, 8'd1);
        take_sum(0, d, o);
        chk("bp_next_dout", d, 32'd2);
        $display("backpressure: next dout=0x%08h", d);

        // Reset in the middle of a frame throws the partial sum away.
        push_beat(32'd1000, 8'd4);
        push_beat(32'd1000, 8'd4);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.o_ready), 32'd1);
        chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        chk("mid_rst_dout",  bus.o_dout,       32'd0);
        chk("mid_rst_ovf",   32'(bus.o_ovf),   32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        push_beat(32'd3, 8'd1);
        take_sum(0, d, o);
        chk("post_rst_dout", d, 32'd2);
        chk("post_rst_ovf", 32'(o), 32'd0);
        $display("mid-frame reset: next dout=0x%08h ovf=%0b", d, o);

        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(0, 6);
            n   = (len == 0) ? 1 : len;
            q.delete();
            for (int b = 0; b < n; b++) begin
                case ($urandom_range(0, 3))
                    0:       q.push_back($urandom);
                    1:       q.push_back(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
                    default: q.push_back(32'($urandom_range(0, 1000)));
                endcase
                repeat ($urandom_range(0, 1)) @(negedge i_clk);
                push_beat(q[b], (b == 0) ? 8'(len) : 8'($urandom));
            end
            model(q, ed, eo);
            chk($sformatf("rnd%0d_latency", f), 32'(bus.o_valid), 32'd1);
            take_sum($urandom_range(0, 3), d, o);
            chk($sformatf("rnd%0d_dout", f), d, ed);
            chk($sformatf("rnd%0d_ovf", f), 32'(o), 32'(eo));
            $display("rnd %0d: len=%0d beats=%0d dout=0x%08h ovf=%0b", f, len, n, d, o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
